sha256_block_padder: RTL and testbench

// - Message-expansion front end of the simplified SHA-256 core. It sits between message memory and the compression stage.
// - Takes start/base/size plus the block count from determine_num_blocks.
// - Fetches message words and emits N*16 padded 32-bit words, 16 per block, in order.
// - Inserts the 0x80000000 pad word, zero fill and the 64-bit message bit length.

---
 rtl/sha256_block_padder.sv | 122 ++++++++++++
 tb/tb_sha256_block_padder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/sha256_block_padder.sv
// sha256_block_padder: fetches message words and emits N padded 16-word SHA-256 blocks.
// Optional stall counter port enabled by SHA256_PADDER_STALL_CNT_EN.
module sha256_block_padder #(
  parameter int ADDR_W = 16,
  parameter int BLK_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] message_addr,
  input  logic [31:0]       size,
  input  logic [BLK_W-1:0]  num_blocks,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  input  logic [31:0]       mem_read_data,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [31:0]       w_data,
  output logic [3:0]        w_index,
  output logic [BLK_W-1:0]  w_block,
  output logic              w_last,
  output logic              busy,
  output logic              done,
  output logic              error
`ifdef SHA256_PADDER_STALL_CNT_EN
  , output logic [15:0]     stall_cnt
`endif
);
  localparam int GW = BLK_W + 4;
  typedef enum logic [2:0] {IDLE, CHECK, READ, CAPTURE, EMIT, DONE} state_t;
  state_t state_q;
  logic [ADDR_W-1:0] base_q;
  logic [31:0] size_q;
  logic [BLK_W-1:0] n_q;
  logic [GW-1:0] g_q, g_d, total;
  logic [31:0] g_ext, pad_d;
  logic is_mem, last_d, bad, advance;
  // g_d is the word about to be presented: the current one after CHECK, the next one after a handshake
  always_comb begin
    total = {n_q, 4'b0};
    g_d = (state_q == EMIT) ? g_q + GW'(1) : g_q;
    g_ext = 32'(g_d);
    is_mem = g_ext < size_q;
    last_d = g_d == total - GW'(1);
    pad_d = (g_ext == size_q) ? 32'h8000_0000 :
            (g_d == total - GW'(2)) ? {27'b0, size_q[31:27]} :
            last_d ? {size_q[26:0], 5'b0} : 32'b0;
    bad = (33'(size_q) + 33'd3 > 33'(total)) || n_q == '0;
    advance = (state_q == CHECK && !bad) || (state_q == EMIT && w_ready && !w_last);
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      base_q <= '0;
      size_q <= '0;
      n_q <= '0;
      g_q <= '0;
      mem_addr <= '0;
      mem_re <= 1'b0;
      w_valid <= 1'b0;
      w_data <= '0;
      w_index <= '0;
      w_block <= '0;
      w_last <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
    end else begin
      mem_re <= 1'b0;
      done <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          base_q <= message_addr;
          size_q <= size;
          n_q <= num_blocks;
          g_q <= '0;
          busy <= 1'b1;
          error <= 1'b0;
          state_q <= CHECK;
        end
        CHECK: if (bad) begin
          error <= 1'b1;
          done <= 1'b1;
          busy <= 1'b0;
          state_q <= IDLE;
        end
        READ: state_q <= CAPTURE;
        CAPTURE: begin
          w_data <= mem_read_data;
          w_valid <= 1'b1;
          state_q <= EMIT;
        end
        EMIT: if (w_ready && w_last) begin
          w_valid <= 1'b0;
          busy <= 1'b0;
          done <= 1'b1;
          state_q <= DONE;
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (advance) begin
        g_q <= g_d;
        w_index <= g_d[3:0];
        w_block <= g_d[GW-1:4];
        w_last <= last_d;
        w_data <= pad_d;
        w_valid <= !is_mem;
        mem_re <= is_mem;
        mem_addr <= base_q + ADDR_W'(g_d);
        state_q <= is_mem ? READ : EMIT;
      end
    end
  end
`ifdef SHA256_PADDER_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset_n) stall_cnt <= '0;
    else if (state_q == IDLE && start) stall_cnt <= '0;
    else if (w_valid && !w_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_sha256_block_padder.sv
// tb_sha256_block_padder: scoreboard bench checking padded output words against a SHA-256 padding model.
module tb_sha256_block_padder;
  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, w_ready = 1'b1;
  logic [15:0] message_addr = '0;
  logic [31:0] size = '0;
  logic [7:0] num_blocks = '0;
  logic [15:0] mem_addr;
  logic mem_re;
  logic [31:0] mem_read_data = '0;
  logic w_valid, w_last, busy, done, error;
  logic [31:0] w_data;
  logic [3:0] w_index;
  logic [7:0] w_block;
`ifdef SHA256_PADDER_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif
  logic [31:0] mem [0:65535];
  logic [44:0] exp_q[$];
  logic [44:0] held = '0;
  int passed = 0, total = 0, cyc = 0, last_hs_cyc = -10, stall_tb = 0;
  bit ready_rand = 0, prev_stall = 0;

  sha256_block_padder dut (
    .clk(clk), .reset_n(reset_n), .start(start), .message_addr(message_addr),
    .size(size), .num_blocks(num_blocks), .mem_addr(mem_addr), .mem_re(mem_re),
    .mem_read_data(mem_read_data), .w_valid(w_valid), .w_ready(w_ready),
    .w_data(w_data), .w_index(w_index), .w_block(w_block), .w_last(w_last),
    .busy(busy), .done(done), .error(error)
`ifdef SHA256_PADDER_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_re) mem_read_data <= mem[mem_addr];

  initial forever begin
    @(posedge clk);
    #1;
    w_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, want);
  endtask

  function automatic logic [127:0] outs();
    return {62'b0, mem_addr, mem_re, w_valid, w_data, w_index, w_block, w_last, busy, done, error};
  endfunction

  always @(negedge clk) begin
    logic [44:0] got;
    got = {w_data, w_index, w_block, w_last};
    if (!reset_n) prev_stall = 0;
    else begin
      if (prev_stall) chk("stall_hold", {w_valid, got}, {1'b1, held});
      if (w_valid && w_ready) begin
        if (exp_q.size() == 0) chk("unexpected_word", got, 45'h0);
        else chk($sformatf("word b%0d i%0d", w_block, w_index), got, exp_q.pop_front());
        if (w_last) last_hs_cyc = cyc;
      end
      if (w_valid && !w_ready) stall_tb++;
      prev_stall = w_valid && !w_ready;
      held = got;
    end
  end

  // Standard SHA-256 padding: message, 0x80 marker word, zeros, then the 64-bit bit length
  task automatic push_expected(input logic [15:0] base, input int unsigned sz, input int n);
    logic [31:0] w[$];
    logic [63:0] bits;
    for (int unsigned i = 0; i < sz; i++) w.push_back(mem[16'(base + i)]);
    w.push_back(32'h8000_0000);
    while (w.size() < n * 16 - 2) w.push_back(32'h0);
    bits = 64'(sz) * 64'd32;
    w.push_back(bits[63:32]);
    w.push_back(bits[31:0]);
    for (int g = 0; g < w.size(); g++)
      exp_q.push_back({w[g], 4'(g % 16), 8'(g / 16), g == w.size() - 1});
  endtask

  task automatic run_case(input logic [15:0] base, input int unsigned sz, input int n, input string tag);
    bit err;
    int lat, done_at;
    err = (64'(sz) + 64'd3 > 64'(n) * 64'd16) || n == 0;
    lat = 0;
    done_at = -1;
    if (!err) push_expected(base, sz, n);
    @(posedge clk);
    #1;
    message_addr = base;
    size = sz;
    num_blocks = 8'(n);
    start = 1'b1;
    stall_tb = 0;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 1; i <= 3000 && done_at < 0; i++) begin
      @(negedge clk);
      if (w_valid && lat == 0) lat = i;
      if (done) done_at = cyc;
    end
    chk({tag, " done_seen"}, done_at >= 0, 1);
    chk({tag, " error"}, error, err);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " drained"}, exp_q.size(), 0);
    if (err) chk({tag, " no_valid"}, lat, 0);
    else begin
      chk({tag, " latency"}, lat, sz > 0 ? 4 : 2);
      chk({tag, " done_after_last"}, done_at, last_hs_cyc + 1);
    end
`ifdef SHA256_PADDER_STALL_CNT_EN
    chk({tag, " stall_cnt"}, stall_cnt, stall_tb);
`endif
    exp_q.delete();
  endtask

  initial begin
    bit found;
    int unsigned sz;
    int n;
    for (int a = 0; a < 65536; a++) mem[a] = $urandom;
    for (int a = 0; a < 5; a++) mem[256 + a] = 32'(a + 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", outs(), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    run_case(16'h0100, 5, 1, "s5n1");
    run_case(16'h0100, 13, 1, "s13n1_exact");
    run_case(16'h0100, 14, 2, "s14n2");
    run_case(16'h2000, 0, 1, "s0n1");
    run_case(16'h0100, 20, 1, "s20n1_err");
    repeat (3) @(negedge clk);
    chk("error_sticky", {error, done}, 2'b10);
    run_case(16'h0100, 20, 2, "s20n2");
    run_case(16'h0100, 0, 0, "n0_err");
    run_case(16'hFFFE, 10, 1, "addr_wrap");
    ready_rand = 1;
    run_case(16'h0100, 5, 1, "s5_stall");
    for (int i = 0; i < 8; i++) begin
      sz = $urandom_range(0, 45);
      n = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 4)) : int'((sz + 18) / 16);
      run_case(16'($urandom), sz, n, $sformatf("rnd%0d", i));
    end
    ready_rand = 0;
    push_expected(16'h0100, 5, 1);
    @(posedge clk);
    #1;
    message_addr = 16'h0100;
    size = 5;
    num_blocks = 8'd1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      found = w_valid && w_index == 4'd3;
    end
    chk("rst_reach_word3", found, 1);
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst_outputs_zero", outs(), 0);
`ifdef SHA256_PADDER_STALL_CNT_EN
    chk("rst_stall_cnt_zero", stall_cnt, 0);
`endif
    exp_q.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_stays_idle", {w_valid, done, busy}, 3'b000);
    end
    run_case(16'h0100, 5, 1, "post_rst");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
